// File: rtl/if_stage_prefetch_pkg.sv
// Shared types for the prefetching fetch stage: FSM encodings and the default
// instruction word shown when no fetched entry is valid.
package if_stage_prefetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_stage_prefetch_if.sv
// Instruction-memory request/response channel; the fetch stage is the master.
interface if_stage_prefetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [INST_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);

endinterface

// File: rtl/if_stage_prefetch_fetch_fifo.sv
// Prefetch queue: power-of-two circular buffer with push/pop/flush; flush
// wins over a simultaneous push.
module if_stage_prefetch_fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push_s, do_pop_s;

  assign full_o    = (cnt_q == DEPTH_C);
  assign empty_o   = (cnt_q == {CNT_W{1'b0}});
  assign count_o   = cnt_q;
  assign rdata_o   = mem_q[rd_q];
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  // Pointer and occupancy next-state
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = {PTR_W{1'b0}};
      rd_d  = {PTR_W{1'b0}};
      cnt_d = {CNT_W{1'b0}};
    end else begin
      wr_d  = do_push_s ? wr_q + {{(PTR_W-1){1'b0}}, 1'b1} : wr_q;
      rd_d  = do_pop_s  ? rd_q + {{(PTR_W-1){1'b0}}, 1'b1} : rd_q;
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, do_push_s} - {{(CNT_W-1){1'b0}}, do_pop_s};
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= {PTR_W{1'b0}};
      rd_q  <= {PTR_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents past the read pointer are don't-care, so no reset
  always_ff @(posedge clk) begin
    if (do_push_s && !flush_i) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/if_stage_prefetch.sv
// Instruction fetch stage with a prefetch queue: one outstanding SRAM request,
// redirects flush the queue and drop any in-flight response.
module if_stage_prefetch
  import if_stage_prefetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1'b1),
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INST_W-1:0] NOP_WORD = INST_W'(NOP_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                branch_taken,
  input  logic [ADDR_W-1:0]   branch_addr,
  if_stage_prefetch_if.master imem,
  output logic                valid,
  output logic [ADDR_W-1:0]   pc,
  output logic [INST_W-1:0]   instruction
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_state_e              state_q, state_d;
  logic [ADDR_W-1:0]         fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]         drop_addr_q, drop_addr_d;
  logic [ADDR_W-1:0]         pc_hold_q;
  logic                      push_s, pop_s, full_s, empty_s;
  logic [CNT_W-1:0]          count_s, count_after_s;
  logic [ADDR_W+INST_W-1:0]  head_s;

  assign push_s = (state_q == ST_WAIT) && imem.imem_ready && !branch_taken;
  assign pop_s  = !empty_s && !freeze && !branch_taken;
  assign count_after_s = count_s + {{(CNT_W-1){1'b0}}, push_s} - {{(CNT_W-1){1'b0}}, pop_s};

  if_stage_prefetch_fetch_fifo #(
    .WIDTH (ADDR_W + INST_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (branch_taken),
    .wdata_i ({fetch_pc_q + PC_STEP, imem.imem_rdata}),
    .rdata_o (head_s),
    .count_o (count_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Fetch FSM next-state; a redirect always retargets fetch_pc
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (branch_taken) begin
          state_d    = ST_WAIT;
          fetch_pc_d = branch_addr;
        end else if (!full_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (branch_taken) begin
          fetch_pc_d = branch_addr;
          if (imem.imem_ready) begin
            state_d = ST_WAIT;
          end else begin
            state_d     = ST_DROP;
            drop_addr_d = fetch_pc_q;
          end
        end else if (imem.imem_ready) begin
          fetch_pc_d = fetch_pc_q + PC_STEP;
          state_d    = (count_after_s < DEPTH_C) ? ST_WAIT : ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DROP: begin
        // The stale request must still complete before a new one may start
        if (branch_taken) begin
          fetch_pc_d = branch_addr;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        state_d = imem.imem_ready ? ST_WAIT : ST_DROP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, fetch address and last-presented PC registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      pc_hold_q   <= {ADDR_W{1'b0}};
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      pc_hold_q   <= empty_s ? pc_hold_q : head_s[ADDR_W+INST_W-1:INST_W];
    end
  end

  // Memory request and decode-side output muxing
  always_comb begin
    imem.imem_req = (state_q != ST_IDLE);
    if (state_q == ST_DROP) begin
      imem.imem_addr = drop_addr_q;
    end else begin
      imem.imem_addr = fetch_pc_q;
    end
    valid = !empty_s;
    if (!empty_s) begin
      pc          = head_s[ADDR_W+INST_W-1:INST_W];
      instruction = head_s[INST_W-1:0];
    end else begin
      pc          = pc_hold_q;
      instruction = NOP_WORD;
    end
  end

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Scoreboard bench for if_stage_prefetch: a behavioural SRAM feeds the stage and
// every accepted response is queued as the expected decode-side output.
module tb_if_stage_prefetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] instruction;

  if_stage_prefetch_if #(.ADDR_W(32), .INST_W(32)) imem_if_i ();

  if_stage_prefetch #(
    .ADDR_W(32), .INST_W(32), .DEPTH(4),
    .PC_STEP(32'd1), .RESET_PC(32'd0), .NOP_WORD(32'd0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem         (imem_if_i),
    .valid        (valid),
    .pc           (pc),
    .instruction  (instruction)
  );

  always #5 clk = ~clk;

  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_bad = 0;
  int          wcnt = 0;
  int          mem_lat = 1;
  int          pop_cnt = 0;
  logic        mem_en = 1'b1;
  logic        stale = 1'b0;
  logic        last_br = 1'b0;
  logic [31:0] exp_fa = 32'd0;
  logic [31:0] last_pc_exp = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_valid"}, valid, 1'b0);
    check_val({tag, "_instr"}, instruction, 32'd0);
    check_val({tag, "_pc"}, pc, 32'd0);
    check_val({tag, "_req"}, imem_if_i.imem_req, 1'b0);
  endtask

  task automatic model_reset();
    sb_q.delete();
    wcnt        = 0;
    stale       = 1'b0;
    exp_fa      = 32'd0;
    last_pc_exp = 32'd0;
    imem_if_i.imem_ready = 1'b0;
  endtask

  // One clock of stimulus, memory response, output check and scoreboard update
  task automatic step(input logic fz, input logic br, input logic [31:0] ba, input logic br_on_rdy);
    logic was_rdy, rdy_now, br_eff;
    exp_t e;
    @(negedge clk);
    was_rdy = imem_if_i.imem_ready;
    imem_if_i.imem_ready = 1'b0;
    if (!mem_en || !imem_if_i.imem_req) begin
      wcnt = 0;
    end else if (!was_rdy && wcnt >= mem_lat) begin
      imem_if_i.imem_ready = 1'b1;
      imem_if_i.imem_rdata = mem_word(imem_if_i.imem_addr);
      wcnt = 0;
    end else begin
      wcnt++;
    end
    rdy_now      = imem_if_i.imem_ready;
    br_eff       = br | (br_on_rdy & rdy_now);
    freeze       = fz;
    branch_taken = br_eff;
    branch_addr  = ba;
    last_br      = br_eff;

    check_val("valid", valid, sb_q.size() != 0);
    if (sb_q.size() != 0) begin
      check_val("pc", pc, sb_q[0].pc);
      check_val("instr", instruction, sb_q[0].inst);
      last_pc_exp = sb_q[0].pc;
      if (!fz && !br_eff) begin
        e = sb_q.pop_front();
        pop_cnt++;
      end
    end else begin
      check_val("nop_instr", instruction, 32'd0);
      check_val("pc_hold", pc, last_pc_exp);
    end

    if (br_eff) begin
      sb_q.delete();
      stale  = rdy_now ? 1'b0 : imem_if_i.imem_req;
      exp_fa = ba;
    end else if (rdy_now) begin
      if (stale) begin
        stale = 1'b0;
      end else begin
        check_val("fetch_addr", imem_if_i.imem_addr, exp_fa);
        e.pc   = imem_if_i.imem_addr + 32'd1;
        e.inst = mem_word(imem_if_i.imem_addr);
        sb_q.push_back(e);
        exp_fa = exp_fa + 32'd1;
      end
    end
  endtask

  initial begin
    logic [31:0] hold_pc, hold_instr, old_addr;
    int          i;
    rst          = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'd0;
    imem_if_i.imem_ready = 1'b0;
    imem_if_i.imem_rdata = 32'd0;
    #3;
    check_reset_outs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Sequential fetch with zero-wait memory
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 32'd0, 1'b0);
    check_val("seq_progress", pop_cnt >= 6, 1'b1);

    // Freeze until the queue is full and requests stop
    for (int k = 0; k < 14; k++) begin
      step(1'b1, 1'b0, 32'd0, 1'b0);
      if (k == 9) begin
        hold_pc    = pc;
        hold_instr = instruction;
      end
    end
    check_val("full_req_low", imem_if_i.imem_req, 1'b0);
    check_val("full_count", sb_q.size(), 4);
    check_val("frz_pc_stable", pc, hold_pc);
    check_val("frz_instr_stable", instruction, hold_instr);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 32'd0, 1'b0);
      check_val("no_gap", valid, 1'b1);
    end

    // Redirect while a 3-wait-state request is outstanding
    mem_lat = 3;
    for (i = 0; i < 30 && !(imem_if_i.imem_req && wcnt == 1 && !imem_if_i.imem_ready); i++)
      step(1'b0, 1'b0, 32'd0, 1'b0);
    check_val("mid_wait_reached", i < 30, 1'b1);
    old_addr = imem_if_i.imem_addr;
    step(1'b0, 1'b1, 32'h40, 1'b0);
    @(posedge clk);
    #1;
    check_val("drop_addr", imem_if_i.imem_addr, old_addr);
    check_val("drop_req", imem_if_i.imem_req, 1'b1);
    check_val("drop_valid", valid, 1'b0);
    for (int k = 0; k < 30; k++) step(1'b0, 1'b0, 32'd0, 1'b0);

    // Redirect coinciding with a memory response
    mem_lat = 1;
    last_br = 1'b0;
    for (i = 0; i < 20 && !last_br; i++) step(1'b0, 1'b0, 32'h80, 1'b1);
    check_val("br_on_ready_hit", last_br, 1'b1);
    @(posedge clk);
    #1;
    check_val("br_rdy_valid", valid, 1'b0);
    check_val("br_rdy_addr", imem_if_i.imem_addr, 32'h80);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 32'd0, 1'b0);

    // Redirect overrides freeze
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 32'd0, 1'b0);
    check_val("frz_pre_valid", valid, 1'b1);
    step(1'b1, 1'b1, 32'h100, 1'b0);
    @(posedge clk);
    #1;
    check_val("frz_flush_valid", valid, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 32'd0, 1'b0);

    // Asynchronous reset in the middle of a request, response arriving in reset
    mem_lat = 3;
    for (i = 0; i < 30 && !(imem_if_i.imem_req && wcnt == 1); i++) step(1'b0, 1'b0, 32'd0, 1'b0);
    check_val("rst_mid_wait", i < 30, 1'b1);
    @(negedge clk);
    #2;
    rst    = 1'b0;
    mem_en = 1'b0;
    freeze = 1'b0;
    branch_taken = 1'b0;
    #1;
    check_reset_outs("async_rst");
    imem_if_i.imem_ready = 1'b1;
    imem_if_i.imem_rdata = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    check_reset_outs("rst_ready");
    @(negedge clk);
    model_reset();
    rst    = 1'b1;
    mem_en = 1'b1;
    mem_lat = 1;
    for (i = 0; i < 10 && !imem_if_i.imem_req; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
    check_val("post_rst_addr", imem_if_i.imem_addr, 32'd0);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 32'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/if_stage_prefetch.md
Name: if_stage_prefetch

Overview:
Parametrised instruction-fetch stage with a prefetch queue, a successor to the single-PC fetch stage. It fetches from a handshaked instruction SRAM port, one request outstanding at a time, and buffers up to DEPTH fetched instructions ahead of decode. Downstream freeze and branch redirect are decoupled from memory latency. It sits between the SRAM/instruction-memory controller and the IF/ID pipeline register.

Parameters:
ADDR_W, 32, PC/instruction address width
INST_W, 32, instruction word width
DEPTH, 4, prefetch queue entries (power of two, >=2)
PC_STEP, 1, PC increment per instruction (word addressing)
RESET_PC, 0, fetch address after reset
NOP_WORD, 0, instruction value presented when no valid entry

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
freeze  in  1  downstream stall; head entry is not consumed
branch_taken  in  1  redirect request from EX
branch_addr  in  ADDR_W  redirect target
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_W  fetch address, stable while imem_req high
imem_ready  in  1  one-cycle pulse: imem_rdata valid, request complete
imem_rdata  in  INST_W  fetched instruction
valid  out  1  pc/instruction hold a real fetched instruction
pc  out  ADDR_W  address of head instruction + PC_STEP (next sequential PC)
instruction  out  INST_W  head instruction, NOP_WORD when valid=0

Behaviour:
- Reset (rst=0, async): queue empty, count=0, fetch_pc=RESET_PC, FSM=IDLE. Outputs: valid=0, instruction=NOP_WORD, pc=0, imem_req=0.
- FSM states IDLE, WAIT, DROP. imem_req=1 in WAIT and DROP; imem_addr=fetch_pc in WAIT, the captured old address in DROP.
- IDLE->WAIT when count < DEPTH and no branch this cycle. A request is only issued when a free slot exists, so no overflow.
- WAIT, imem_ready=1: push {fetch_pc+PC_STEP, imem_rdata}; fetch_pc += PC_STEP (wraps mod 2^ADDR_W). Go WAIT if count after push/pop < DEPTH, else IDLE.
- DROP, imem_ready=1: discard data; go WAIT at the redirected fetch_pc.
- Consume: pop head when valid=1 and freeze=0 and branch_taken=0. Push and pop in the same cycle leave count unchanged.
- Branch (highest priority, overrides freeze):
  - Flush queue (count=0) and set fetch_pc=branch_addr.
  - WAIT without imem_ready -> DROP.
  - WAIT with imem_ready -> the response is discarded, go WAIT.
  - IDLE -> WAIT.
  - DROP -> stays DROP.
  - valid=0 from the next cycle until the first new entry is pushed.
- Latency: request in cycle t, imem_ready in cycle t+k, valid=1 at t+k+1. Best-case redirect-to-valid is 2 cycles with zero-wait memory.
- Outputs are combinational from the queue head. When valid=0: instruction=NOP_WORD and pc holds its last value.
- Reset mid-transaction: state clears immediately. A late imem_ready after reset is ignored because FSM=IDLE.
- Full queue with freeze held: no requests are issued, and outputs are stable indefinitely.

Decomposition:
- Shared defines header holds the FSM state encodings (IDLE/WAIT/DROP) and the default NOP_WORD.
- One sub-module: fetch_fifo (DEPTH x (ADDR_W+INST_W)). It has push/pop/flush, count, full and empty; flush has priority over push.
- FSM, fetch_pc and output muxing stay in if_stage_prefetch.

Test Plan:
- Reset, zero-wait memory (imem_ready the cycle after imem_req), freeze=0 -> imem_addr 0,1,2,...; valid=1 from cycle 2; instruction matches mem[0],mem[1],...; pc=1,2,3,....
- freeze=1 for 10 cycles, DEPTH=4 -> queue fills to 4 and imem_req drops. pc/instruction hold mem[n]. On release, 4 consecutive pops occur with no gaps.
- 3-wait-state memory, branch_taken with branch_addr=0x40 while in WAIT -> state DROP and the old data is discarded. Next request has imem_addr=0x40, and the first valid output has pc=0x41 with instruction mem[0x40].
- branch_taken and imem_ready in the same cycle -> that response is never presented. Next imem_addr=branch_addr; queue is empty the next cycle.
- branch_taken with freeze=1 -> flush still occurs; valid=0 the next cycle.
- rst pulsed low mid-WAIT, with imem_ready arriving during reset -> all outputs at reset values. After release, the first imem_addr is RESET_PC.
